// File: rtl/pll_clken_pkg.sv
// pll_clken_pkg: shared FSM state type and channel-select width helper for pll_clken_gen.
package pll_clken_pkg;
    typedef enum logic [1:0] {WAIT_LOCK, SETTLE, RUN, RECONFIG} state_t;

    function automatic int ch_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction
endpackage

// File: rtl/pll_clken_acc.sv
// pll_clken_acc: one phase accumulator whose registered carry-out is the enable pulse.
// Optional PLL_CLKEN_TOGGLE_EN adds a toggle flop giving a half-enable-rate square wave.
module pll_clken_acc import pll_clken_pkg::*; #(
    parameter int ACC_W = 16
) (
    input  logic             refclk,
    input  logic             rst,
    input  logic             clear,
    input  logic             run,
    input  logic [ACC_W-1:0] inc,
    output logic             en
`ifdef PLL_CLKEN_TOGGLE_EN
   ,output logic             tgl
`endif
);
    logic [ACC_W-1:0] acc;

    always_ff @(posedge refclk) begin
        if (rst || clear) begin
            acc <= '0;
            en  <= 1'b0;
        end else if (run) begin
            {en, acc} <= {1'b0, acc} + {1'b0, inc};
        end
    end

`ifdef PLL_CLKEN_TOGGLE_EN
    always_ff @(posedge refclk) begin
        if (rst || clear) tgl <= 1'b0;
        else if (run)     tgl <= tgl ^ en;
    end
`endif
endmodule

// File: rtl/pll_clken_gen.sv
// pll_clken_gen: lock-qualified multi-channel fractional clock-enable generator in the refclk domain.
// Optional PLL_CLKEN_TOGGLE_EN adds the clk_tgl square-wave outputs.
module pll_clken_gen import pll_clken_pkg::*; #(
    parameter int                        NUM_CH        = 4,
    parameter int                        ACC_W         = 16,
    parameter int                        SETTLE_CYCLES = 1024,
    parameter logic [NUM_CH*ACC_W-1:0]   INIT_INC      = {NUM_CH{16'h4000}}
) (
    input  logic                     refclk,
    input  logic                     rst,
    input  logic                     pll_locked_in,
    input  logic                     cfg_valid,
    output logic                     cfg_ready,
    input  logic [ch_w(NUM_CH)-1:0]  cfg_ch,
    input  logic [ACC_W-1:0]         cfg_inc,
    output logic [NUM_CH-1:0]        clk_en,
`ifdef PLL_CLKEN_TOGGLE_EN
    output logic [NUM_CH-1:0]        clk_tgl,
`endif
    output logic                     locked
);
    localparam int CH_W  = ch_w(NUM_CH);
    localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);

    state_t           state, state_n;
    logic             s1, lk_s;
    logic [CNT_W-1:0] cnt;
    logic [ACC_W-1:0] inc [NUM_CH];
    logic             xfer, ch_ok, run;

    assign xfer   = cfg_valid && cfg_ready;
    assign ch_ok  = 32'(cfg_ch) < NUM_CH;
    assign locked = state == RUN;
    // accumulators advance only while staying in RUN, so a leaving edge clears them with the pulse
    assign run    = state == RUN && state_n == RUN;

    always_comb begin
        state_n = state;
        case (state)
            WAIT_LOCK: state_n = lk_s ? SETTLE : WAIT_LOCK;
            SETTLE:    state_n = !lk_s ? WAIT_LOCK : (xfer && ch_ok) ? RECONFIG :
                                 (cnt == CNT_W'(SETTLE_CYCLES - 1)) ? RUN : SETTLE;
            RUN:       state_n = !lk_s ? WAIT_LOCK : (xfer && ch_ok) ? RECONFIG : RUN;
            default:   state_n = SETTLE;
        endcase
    end

    always_ff @(posedge refclk) begin
        if (rst) begin
            state     <= WAIT_LOCK;
            s1        <= 1'b0;
            lk_s      <= 1'b0;
            cnt       <= '0;
            cfg_ready <= 1'b0;
        end else begin
            state     <= state_n;
            s1        <= pll_locked_in;
            lk_s      <= s1;
            cnt       <= (state == SETTLE && state_n == SETTLE) ? cnt + CNT_W'(1) : '0;
            cfg_ready <= state_n != RECONFIG;
        end
    end

    always_ff @(posedge refclk) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (rst)
                inc[i] <= INIT_INC[i*ACC_W +: ACC_W];
            else if (xfer && ch_ok && cfg_ch == CH_W'(i))
                inc[i] <= cfg_inc;
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        pll_clken_acc #(.ACC_W(ACC_W)) u_acc (
            .refclk (refclk),
            .rst    (rst),
            .clear  (!run),
            .run    (run),
            .inc    (inc[c]),
            .en     (clk_en[c])
`ifdef PLL_CLKEN_TOGGLE_EN
           ,.tgl    (clk_tgl[c])
`endif
        );
    end
endmodule

// File: doc/pll_clken_gen.md
Name: pll_clken_gen

Overview:
- Multi-channel fractional clock-enable generator that runs in the PLL output domain (refclk).
- Qualifies the PLL lock status, waits for a programmable settle time, then produces NUM_CH independent single-cycle enable pulses from per-channel phase accumulators.
- Lets logic run at derived rates without extra PLL outputs.
- Supports runtime rate reprogramming through a valid/ready config port.

Parameters:
- NUM_CH, 4, number of enable channels (1..16).
- ACC_W, 16, phase accumulator width; rate = inc / 2^ACC_W of refclk.
- SETTLE_CYCLES, 1024, cycles lock must hold before outputs run (>=1).
- INIT_INC, {NUM_CH{16'h4000}}, packed NUM_CH*ACC_W reset increments; channel 0 in the LSBs.

Ports:
- refclk  in  1  sole clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- pll_locked_in  in  1  raw lock from PLL, asynchronous to refclk.
- cfg_valid  in  1  config request.
- cfg_ready  out  1  config accept.
- cfg_ch  in  CH_W  target channel; CH_W = max(1, clog2(NUM_CH)).
- cfg_inc  in  ACC_W  new increment for cfg_ch.
- clk_en  out  NUM_CH  per-channel one-cycle enable pulses.
- locked  out  1  high while enables are valid.

Behaviour:
- Reset (rst=1 at an edge):
  - state=WAIT_LOCK; sync flops, settle counter and accumulators are 0.
  - inc[ch] = INIT_INC slice.
  - clk_en=0, locked=0, cfg_ready=0.
  - rst overrides every other input in the same cycle.
- Lock synchroniser: pll_locked_in passes through 2 flops to give lk_s (2-cycle latency). Only lk_s is used.
- WAIT_LOCK:
  - clk_en=0, locked=0, accumulators held at 0.
  - lk_s=1 -> SETTLE with counter=0.
- SETTLE:
  - Counter increments each cycle.
  - Counter reaches SETTLE_CYCLES-1 with lk_s=1 -> RUN.
  - lk_s=0 at any point -> WAIT_LOCK, counter cleared.
- RUN:
  - locked=1 (registered; equals state==RUN).
  - Each cycle every accumulator adds its inc in ACC_W+1 bits and keeps the low ACC_W bits. The carry-out is registered into clk_en[ch].
  - Result: with inc=2^(ACC_W-2), clk_en[ch] pulses every 4th cycle, first pulse 4 cycles after locked rises.
  - lk_s=0 -> WAIT_LOCK next edge: locked=0, clk_en=0, accumulators cleared.
- RECONFIG:
  - One-cycle state entered when a config is accepted while in RUN or SETTLE.
  - All accumulators are cleared (phase realignment), locked=0, clk_en=0.
  - Then -> SETTLE with counter=0.
- Config handshake:
  - cfg_ready=1 in WAIT_LOCK, SETTLE and RUN; 0 in RECONFIG and reset.
  - Transfer occurs when cfg_valid && cfg_ready at an edge.
  - inc[cfg_ch] <= cfg_inc.
  - In WAIT_LOCK: write only, no state change.
  - cfg_ch >= NUM_CH: transfer is accepted and fully ignored (no write, no state change).
- Boundary conditions:
  - cfg_inc=0 disables the channel (clk_en never pulses).
  - Maximum cfg_inc = 2^ACC_W-1 gives pulses on all but one cycle per 2^ACC_W.
  - lk_s drop and config transfer on the same edge: the lock loss wins (-> WAIT_LOCK), but the inc write is still performed.
- Wrap-around: the accumulator wraps modulo 2^ACC_W, so fractional rates are exact on average (jitter ±1 refclk cycle).

Optional Feature:
- Macro: PLL_CLKEN_TOGGLE_EN.
- When defined:
  - Adds output clk_tgl [NUM_CH].
  - Each bit flips on every cycle its clk_en bit is 1, giving a square wave at half the enable rate.
  - Reset to 0; forced to 0 whenever locked=0.
- When undefined: the port and its flops are absent; all other behaviour is identical.

Decomposition:
- Package pll_clken_pkg holds:
  - state enum {WAIT_LOCK, SETTLE, RUN, RECONFIG} (2 bits);
  - function ch_w(n) returning max(1, clog2(n)).
- Sub-module pll_clken_acc (one accumulator + carry register + optional toggle flop):
  - Inputs: clear, run, inc.
  - Outputs: en and tgl.
  - Instantiated NUM_CH times via generate.
- The top level owns the synchroniser, FSM, settle counter, inc registers and cfg handshake.

Test Plan:
- Lock bring-up: SETTLE_CYCLES=8, pll_locked_in high at cycle 10 after rst release -> locked rises at cycle 10+2+8 (±1); clk_en[0] (inc=0x4000) then pulses every 4 cycles.
- Fractional rate: cfg ch1 inc=0x5555 in RUN -> locked drops for 1+SETTLE_CYCLES cycles, then clk_en[1] gives 1 pulse per 3 cycles averaged over 3000 cycles (count 1000±1).
- Lock loss: drop pll_locked_in mid-RUN -> locked=0 and clk_en=0 exactly 3 edges later; re-lock -> full settle again.
- Config edge cases:
  - cfg_ch=7 with NUM_CH=4 -> accepted, with no change to locked or any clk_en stream;
  - cfg_inc=0 -> channel stays silent for 1000 cycles.
- Reset mid-RECONFIG and mid-SETTLE -> next cycle all outputs 0 and inc restored to INIT_INC.
- With PLL_CLKEN_TOGGLE_EN and inc=0x4000 -> clk_tgl[0] period 8 cycles, 50% duty.
